// File: rtl/fa_if_adder.sv
// Registered, valid/ready-handshaked WIDTH-bit ripple-carry adder.
// One result slot; each bit cell is a full adder built from two half adders.
module fa_if_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s_out,
  output logic             c_out,
  output logic             ovf
);

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
  } res_t;

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("fa_if_adder: WIDTH must be in 1..64");
  end

  logic [WIDTH:0]   cy;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] hp;   // first half-adder sum (propagate)
  logic [WIDTH-1:0] hg;   // first half-adder carry (generate)
  logic [WIDTH-1:0] ht;   // second half-adder carry
  res_t             res_d, res_q;
  logic             acc;

  assign cy[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign hp[i]   = a[i] ^ b[i];
    assign hg[i]   = a[i] & b[i];
    assign sum[i]  = hp[i] ^ cy[i];
    assign ht[i]   = hp[i] & cy[i];
    assign cy[i+1] = hg[i] | ht[i];
  end

  // Signed overflow: carry into MSB differs from carry out of MSB.
  assign res_d.s   = sum;
  assign res_d.co  = cy[WIDTH];
  assign res_d.ovf = cy[WIDTH] ^ cy[WIDTH-1];

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res_q     <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      res_q     <= res_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign s_out = res_q.s;
  assign c_out = res_q.co;
  assign ovf   = res_q.ovf;

endmodule

// File: tb/tb_fa_if_adder.sv
// Drives WIDTH=1, 8 and 16 instances with shared handshake/operands and checks
// each against a queued expected-result model of the single-entry slot.
module tb_fa_if_adder;

  typedef struct packed {
    logic [15:0] s16; logic c16; logic o16;
    logic [7:0]  s8;  logic c8;  logic o8;
    logic        s1;  logic c1;  logic o1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv = 1'b0, ordy = 1'b0, c = 1'b0;
  logic [15:0] a = '0, b = '0;

  logic        rdy1, ov1, co1, of1;
  logic [0:0]  s1;
  logic        rdy8, ov8, co8, of8;
  logic [7:0]  s8;
  logic        rdy16, ov16, co16, of16;
  logic [15:0] s16;

  int   nerr = 0, nchk = 0;
  exp_t sb[$];
  logic m_vld = 1'b0;

  always #5 clk = ~clk;

  fa_if_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(rdy1),
    .a(a[0:0]), .b(b[0:0]), .c(c), .out_valid(ov1), .out_ready(ordy),
    .s_out(s1), .c_out(co1), .ovf(of1));

  fa_if_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(rdy8),
    .a(a[7:0]), .b(b[7:0]), .c(c), .out_valid(ov8), .out_ready(ordy),
    .s_out(s8), .c_out(co8), .ovf(of8));

  fa_if_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(rdy16),
    .a(a), .b(b), .c(c), .out_valid(ov16), .out_ready(ordy),
    .s_out(s16), .c_out(co16), .ovf(of16));

  // Overflow from sign rule: same operand signs, result sign differs.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic ci);
    exp_t        r;
    logic [16:0] f16;
    logic [8:0]  f8;
    logic [1:0]  f1;
    f16   = {1'b0, x} + {1'b0, y} + {16'b0, ci};
    f8    = {1'b0, x[7:0]} + {1'b0, y[7:0]} + {8'b0, ci};
    f1    = {1'b0, x[0]} + {1'b0, y[0]} + {1'b0, ci};
    r.s16 = f16[15:0]; r.c16 = f16[16];
    r.o16 = (x[15] == y[15]) && (f16[15] != x[15]);
    r.s8  = f8[7:0];   r.c8  = f8[8];
    r.o8  = (x[7] == y[7]) && (f8[7] != x[7]);
    r.s1  = f1[0];     r.c1  = f1[1];
    r.o1  = (x[0] == y[0]) && (f1[0] != x[0]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check current outputs against the model, update model, clock.
  task automatic step(input logic iv_i, input logic [15:0] a_i, input logic [15:0] b_i,
                      input logic c_i, input logic ordy_i);
    exp_t e;
    logic acc;
    logic rdy_e;
    iv = iv_i; a = a_i; b = b_i; c = c_i; ordy = ordy_i;
    #1;
    rdy_e = !m_vld || ordy_i;
    chk("out_valid_w1",  16'(ov1),   16'(m_vld));
    chk("out_valid_w8",  16'(ov8),   16'(m_vld));
    chk("out_valid_w16", 16'(ov16),  16'(m_vld));
    chk("in_ready_w1",   16'(rdy1),  16'(rdy_e));
    chk("in_ready_w8",   16'(rdy8),  16'(rdy_e));
    chk("in_ready_w16",  16'(rdy16), 16'(rdy_e));
    if (m_vld && sb.size() > 0) begin
      e = sb[0];
      chk("s_out_w1",  16'(s1),   16'(e.s1));
      chk("c_out_w1",  16'(co1),  16'(e.c1));
      chk("ovf_w1",    16'(of1),  16'(e.o1));
      chk("s_out_w8",  16'(s8),   16'(e.s8));
      chk("c_out_w8",  16'(co8),  16'(e.c8));
      chk("ovf_w8",    16'(of8),  16'(e.o8));
      chk("s_out_w16", s16,       e.s16);
      chk("c_out_w16", 16'(co16), 16'(e.c16));
      chk("ovf_w16",   16'(of16), 16'(e.o16));
    end
    acc = iv_i && rdy_e;
    if (m_vld && ordy_i) void'(sb.pop_front());
    if (acc) sb.push_back(model(a_i, b_i, c_i));
    m_vld = acc || (m_vld && !ordy_i);
    @(posedge clk); #1;
  endtask

  // Reset edge with live operands presented; nothing may be accepted.
  task automatic do_reset();
    rst_n = 1'b0; iv = 1'b1; a = 16'h1234; b = 16'h4321; c = 1'b1; ordy = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; iv = 1'b0;
    #1;
    chk("rst_out_valid_w1",  16'(ov1),  16'd0);
    chk("rst_out_valid_w8",  16'(ov8),  16'd0);
    chk("rst_out_valid_w16", 16'(ov16), 16'd0);
    chk("rst_s_out_w1",      16'(s1),   16'd0);
    chk("rst_s_out_w8",      16'(s8),   16'd0);
    chk("rst_s_out_w16",     s16,       16'd0);
    chk("rst_c_out_w8",      16'(co8),  16'd0);
    chk("rst_c_out_w16",     16'(co16), 16'd0);
    chk("rst_ovf_w8",        16'(of8),  16'd0);
    chk("rst_ovf_w16",       16'(of16), 16'd0);
    ordy = 1'b0;
    #1;
    chk("rst_in_ready_w8",   16'(rdy8),  16'd1);
    chk("rst_in_ready_w16",  16'(rdy16), 16'd1);
    sb.delete();
    m_vld = 1'b0;
  endtask

  initial begin
    do_reset();

    // Single-bit sequence, then all eight single-bit combinations.
    step(1'b1, 16'h1, 16'h0, 1'b0, 1'b1);
    step(1'b1, 16'h1, 16'h1, 1'b0, 1'b1);
    step(1'b1, 16'h1, 16'h1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++)
      step(1'b1, {15'b0, i[2]}, {15'b0, i[1]}, i[0], 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

    // 8-bit carry/overflow corners.
    step(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1);
    step(1'b1, 16'h007F, 16'h0001, 1'b0, 1'b1);
    step(1'b1, 16'h0080, 16'h0080, 1'b1, 1'b1);
    step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

    // Backpressure: 3+4 held through three stalled cycles, then refill on release.
    step(1'b1, 16'd3, 16'd4, 1'b0, 1'b1);
    step(1'b1, 16'h55, 16'h22, 1'b0, 1'b0);
    step(1'b1, 16'h66, 16'h11, 1'b1, 1'b0);
    step(1'b1, 16'h77, 16'h01, 1'b0, 1'b0);
    step(1'b1, 16'd10, 16'd20, 1'b0, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

    // Reset while a nonzero result is held.
    step(1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    do_reset();

    // Randomized streaming with random valid and backpressure.
    repeat (400)
      step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
